// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready front end for a single-port synchronous RAM.
// Turns one request at a time into RAM write/read cycles, returns read data
// on a response channel, and optionally clears the RAM after reset.
// Every output comes straight from a flop; the next-cycle output values are
// computed together with the next state, so there is no input-to-output path.
`timescale 1ns/1ps

module ram_access_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           DEPTH      = 16,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    // One extra counter bit so the clear sweep can count up to DEPTH itself.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam state_t RESET_STATE = INIT_EN ? ST_INIT : ST_IDLE;

    state_t                  state_q,     state_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic                    we_q,        we_d;
    logic                    in_range_q,  in_range_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic                    init_done_q, init_done_d;
    logic                    ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_q,   ram_din_d;

    logic req_accept;
    logic addr_ok;

    // Handshake and range decode for the request presented this cycle.
    assign req_accept = req_valid & req_ready_q;
    assign addr_ok    = {1'b0, req_addr} < DEPTH_C;

    // Next-state and next-output logic for the controller FSM.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        in_range_d  = in_range_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        init_done_d = init_done_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == DEPTH_C) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    ram_din_d  = INIT_VALUE;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                req_ready_d = 1'b1;
                if (req_accept) begin
                    state_d     = ST_ISSUE;
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    in_range_d  = addr_ok;
                    // Out-of-range requests never touch the RAM pins.
                    if (addr_ok) begin
                        ram_we_d   = req_we;
                        ram_addr_d = req_addr;
                        if (req_we) begin
                            ram_din_d = req_wdata;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    // Writes are posted; out-of-range writes are dropped silently.
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else if (in_range_q) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_CAPTURE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ram_dout;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State and output registers; reset clears everything and restarts INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            in_range_q  <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            in_range_q  <= in_range_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            init_done_q <= init_done_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed scenarios followed by random traffic,
// with a behavioural single-port RAM behind the controller and a word-array
// reference model of what the RAM should hold.
`timescale 1ns/1ps

module tb_ram_access_ctrl;

    localparam int unsigned AW       = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned DEPTH    = 12;
    localparam logic [7:0]  INIT_VAL = 8'h00;
    localparam int          BOUND    = 40;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          init_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: expected content of every populated word.
    logic [7:0] exp_mem [DEPTH];

    // Physical RAM behind the controller; full address space, pre-filled with junk.
    logic [7:0] ram_mem [16] = '{default: 8'hEE};

    ram_access_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .INIT_EN    (1'b1),
        .INIT_VALUE (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM: write or read per edge, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        else        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_ram_we"},    32'(ram_we),    32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        check({tag, "_ram_din"},   32'(ram_din),   32'd0);
    endtask

    // Called at the negedge where rst_n has just been released.
    task automatic run_init(input string tag);
        int nwe = 0;
        check({tag, "_we_at_release"}, 32'(ram_we), 32'd0);
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (ram_we) begin
                check({tag, "_addr"}, 32'(ram_addr), 32'(nwe));
                check({tag, "_din"},  32'(ram_din),  32'(INIT_VAL));
                check({tag, "_busy"}, {30'd0, req_ready, rsp_valid}, 32'd0);
                nwe++;
            end
            if (init_done) break;
        end
        check({tag, "_we_cycles"}, 32'(nwe), 32'(DEPTH));
        check({tag, "_done"},      32'(init_done), 32'd1);
        check({tag, "_ready"},     32'(req_ready), 32'd1);
        check({tag, "_idle_we"},   32'(ram_we),    32'd0);
        for (int a = 0; a < int'(DEPTH); a++) exp_mem[a] = INIT_VAL;
    endtask

    // Present a request at a negedge, hold until accepted; returns at the negedge after accept.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit got = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        for (int i = 0; i < BOUND; i++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit ok = (int'(addr) < int'(DEPTH));
        int gap = 0;
        send(1'b1, addr, data);
        check("wr_ram_we", 32'(ram_we), 32'(ok));
        if (ok) begin
            check("wr_ram_addr", 32'(ram_addr), 32'(addr));
            check("wr_ram_din",  32'(ram_din),  32'(data));
            exp_mem[addr] = data;
        end
        while (!req_ready && gap < BOUND) begin
            @(negedge clk);
            gap++;
        end
        check("wr_gap", 32'(gap), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int stall);
        bit ok = (int'(addr) < int'(DEPTH));
        logic [7:0] exp_d = 8'h00;
        int lat = 0;
        if (ok) exp_d = exp_mem[addr];
        rsp_ready = (stall == 0);
        send(1'b0, addr, 8'h00);
        check("rd_ram_we", 32'(ram_we), 32'd0);
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), ok ? 32'd2 : 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("rd_stall_valid", 32'(rsp_valid), 32'd1);
            check("rd_stall_data",  {23'd0, rsp_err, rsp_rdata}, {23'd0, !ok, exp_d});
            check("rd_stall_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rd_rdata", 32'(rsp_rdata), 32'(exp_d));
        check("rd_err",   32'(rsp_err),   32'(!ok));
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rd_valid_drop", 32'(rsp_valid), 32'd0);
        check("rd_ready_back", 32'(req_ready), 32'd1);
    endtask

    logic [7:0] b2b_vals [3] = '{8'h11, 8'h22, 8'h33};
    int         acc_cyc  [3];

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) exp_mem[a] = 8'hEE;

        // Reset state, then the clear sweep.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        run_init("init");

        // Read of a cleared word with a long response stall.
        do_read(4'd7, 5);

        // Write then read back.
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 0);

        // Out-of-range write is dropped, out-of-range read errors, top word is fine.
        do_write(4'd13, 8'h5A);
        check("oor_wr_untouched", 32'(ram_mem[13]), 32'hEE);
        do_read(4'd13, 0);
        do_read(4'd11, 2);

        // Back-to-back writes with req_valid held high throughout.
        req_valid = 1'b1;
        req_we    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bit got = 1'b0;
            req_addr  = 4'(k);
            req_wdata = b2b_vals[k];
            for (int i = 0; i < BOUND; i++) begin
                if (req_ready) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) check("b2b_timeout", 32'd0, 32'd1);
            acc_cyc[k] = cyc;
            @(posedge clk);
            @(negedge clk);
            exp_mem[k] = b2b_vals[k];
        end
        req_valid = 1'b0;
        check("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        check("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
        for (int k = 0; k < 3; k++) do_read(4'(k), 0);

        // Random traffic against the word-array model.
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else                           do_read(a, int'($urandom_range(0, 3)));
        end

        // RAM contents agree with the model; unpopulated words never written.
        for (int a = 0; a < 16; a++) begin
            if (a < int'(DEPTH)) check("final_mem", 32'(ram_mem[a]), 32'(exp_mem[a]));
            else                 check("final_oor_mem", 32'(ram_mem[a]), 32'hEE);
        end

        // Reset while a read sits in CAPTURE.
        do_write(4'd5, 8'h9C);
        rsp_ready = 1'b0;
        send(1'b0, 4'd5, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_capture");
        @(negedge clk);
        rst_n = 1'b1;
        run_init("reinit_a");
        check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        do_read(4'd5, 0);

        // Reset in the middle of the clear sweep, at address 9.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < BOUND; i++) begin
                @(negedge clk);
                if (ram_we && ram_addr == 4'd9) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("init_reached_9", 32'(hit), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        run_init("reinit_b");
        do_read(4'd2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
